// File: rtl/btb_pkg.sv
// Shared types, constants and helpers for the associative branch target buffer
// and the flush-resolution logic that trains it.
package btb_pkg;

    typedef enum logic [1:0] {
        KIND_JMP   = 2'd0,
        KIND_BR_T  = 2'd1,
        KIND_BR_NT = 2'd2,
        KIND_JR    = 2'd3
    } kind_e;

    typedef enum logic [2:0] {
        NICE_PRED = 3'd0,
        JMP_FLUSH = 3'd1,
        BR_FLUSH  = 3'd2,
        NBR_FLUSH = 3'd3,
        JR_FLUSH  = 3'd4
    } flush_e;

    localparam logic [1:0] CTR_WEAK_T   = 2'd2;
    localparam logic [1:0] CTR_STRONG_T = 2'd3;

    // A correct prediction carries no new information, so it maps to the
    // not-taken kind, which never allocates on a miss.
    function automatic kind_e flush_to_kind(input flush_e code);
        case (code)
            JMP_FLUSH: return KIND_JMP;
            BR_FLUSH:  return KIND_BR_T;
            NBR_FLUSH: return KIND_BR_NT;
            JR_FLUSH:  return KIND_JR;
            default:   return KIND_BR_NT;
        endcase
    endfunction

    function automatic logic kind_is_uncond(input kind_e k);
        return (k == KIND_JMP) || (k == KIND_JR);
    endfunction

    function automatic logic kind_is_taken(input kind_e k);
        return k != KIND_BR_NT;
    endfunction

    function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input kind_e k);
        case (k)
            KIND_BR_T:  return (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
            KIND_BR_NT: return (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
            default:    return CTR_STRONG_T;
        endcase
    endfunction

    function automatic logic [1:0] ctr_init(input kind_e k);
        case (k)
            KIND_BR_T: return CTR_WEAK_T;
            default:   return CTR_STRONG_T;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/btb_way.sv
// One way of the branch target buffer: per-set storage, a lookup compare port,
// an update compare port and a single write port addressed by the update index.
module btb_way
    import btb_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int IDX_BITS  = 6,
    parameter int TAG_BITS  = WORD_SIZE - IDX_BITS
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic [IDX_BITS-1:0]  rd_idx_i,
    input  logic [TAG_BITS-1:0]  rd_tag_i,
    output logic                 rd_hit_o,
    output logic [WORD_SIZE-1:0] rd_target_o,
    output kind_e                rd_kind_o,
    output logic [1:0]           rd_ctr_o,
    input  logic [IDX_BITS-1:0]  up_idx_i,
    input  logic [TAG_BITS-1:0]  up_tag_i,
    output logic                 up_valid_o,
    output logic                 up_hit_o,
    output logic [WORD_SIZE-1:0] up_target_o,
    output kind_e                up_kind_o,
    output logic [1:0]           up_ctr_o,
    input  logic                 we_i,
    input  logic [WORD_SIZE-1:0] wr_target_i,
    input  kind_e                wr_kind_i,
    input  logic [1:0]           wr_ctr_i
);
    localparam int SETS = 1 << IDX_BITS;

    logic [SETS-1:0]      valid_q;
    logic [TAG_BITS-1:0]  tag_q    [SETS];
    logic [WORD_SIZE-1:0] target_q [SETS];
    kind_e                kind_q   [SETS];
    logic [1:0]           ctr_q    [SETS];

    assign rd_hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_target_o = target_q[rd_idx_i];
    assign rd_kind_o   = kind_q[rd_idx_i];
    assign rd_ctr_o    = ctr_q[rd_idx_i];

    assign up_valid_o  = valid_q[up_idx_i];
    assign up_hit_o    = valid_q[up_idx_i] && (tag_q[up_idx_i] == up_tag_i);
    assign up_target_o = target_q[up_idx_i];
    assign up_kind_o   = kind_q[up_idx_i];
    assign up_ctr_o    = ctr_q[up_idx_i];

    // Entry storage; invalidate-all wins over a write in the same cycle.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                tag_q[s]    <= '0;
                target_q[s] <= '0;
                kind_q[s]   <= KIND_JMP;
                ctr_q[s]    <= 2'd0;
            end
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[up_idx_i]  <= 1'b1;
            tag_q[up_idx_i]    <= up_tag_i;
            target_q[up_idx_i] <= wr_target_i;
            kind_q[up_idx_i]   <= wr_kind_i;
            ctr_q[up_idx_i]    <= wr_ctr_i;
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative (1 or 2 way) branch target buffer with LRU replacement.
// Optional statistics counters are enabled by defining BTB_ASSOC_STATS_EN.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int IDX_BITS  = 6,
    parameter int WAYS      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] pred_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic [1:0]           upd_kind,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 flush_all
`ifdef BTB_ASSOC_STATS_EN
    ,
    output logic [15:0]          stat_lookups,
    output logic [15:0]          stat_hits,
    output logic [15:0]          stat_mispred
`endif
);
    localparam int TAG_BITS = WORD_SIZE - IDX_BITS;
    localparam int SETS     = 1 << IDX_BITS;

    if ((WAYS != 1) && (WAYS != 2)) begin : g_bad_ways
        $error("btb_assoc: WAYS must be 1 or 2");
    end

    logic [IDX_BITS-1:0]  rd_idx_s, up_idx_s;
    logic [TAG_BITS-1:0]  rd_tag_s, up_tag_s;
    kind_e                upd_kind_s;
    logic [WAYS-1:0]      rd_hit_s, up_vld_s, up_hit_s, we_s;
    logic [WORD_SIZE-1:0] rd_target_s [WAYS];
    kind_e                rd_kind_s   [WAYS];
    logic [1:0]           rd_ctr_s    [WAYS];
    logic [WORD_SIZE-1:0] up_target_s [WAYS];
    kind_e                up_kind_s   [WAYS];
    logic [1:0]           up_ctr_s    [WAYS];

    logic [WORD_SIZE-1:0] sel_target_s, up_cur_target_s;
    kind_e                sel_kind_s, up_cur_kind_s;
    logic [1:0]           sel_ctr_s, up_cur_ctr_s, wr_ctr_s;
    logic                 up_any_hit_s, do_write_s, lru_s;
    logic                 up_way_s, victim_s, wr_way_s;

    assign rd_idx_s   = pc[IDX_BITS-1:0];
    assign rd_tag_s   = pc[WORD_SIZE-1:IDX_BITS];
    assign up_idx_s   = upd_pc[IDX_BITS-1:0];
    assign up_tag_s   = upd_pc[WORD_SIZE-1:IDX_BITS];
    assign upd_kind_s = kind_e'(upd_kind);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        btb_way #(
            .WORD_SIZE (WORD_SIZE),
            .IDX_BITS  (IDX_BITS),
            .TAG_BITS  (TAG_BITS)
        ) u_way (
            .clk         (clk),
            .rst_i       (reset),
            .flush_i     (flush_all),
            .rd_idx_i    (rd_idx_s),
            .rd_tag_i    (rd_tag_s),
            .rd_hit_o    (rd_hit_s[w]),
            .rd_target_o (rd_target_s[w]),
            .rd_kind_o   (rd_kind_s[w]),
            .rd_ctr_o    (rd_ctr_s[w]),
            .up_idx_i    (up_idx_s),
            .up_tag_i    (up_tag_s),
            .up_valid_o  (up_vld_s[w]),
            .up_hit_o    (up_hit_s[w]),
            .up_target_o (up_target_s[w]),
            .up_kind_o   (up_kind_s[w]),
            .up_ctr_o    (up_ctr_s[w]),
            .we_i        (we_s[w]),
            .wr_target_i (upd_target),
            .wr_kind_i   (upd_kind_s),
            .wr_ctr_i    (wr_ctr_s)
        );
    end

    // Prediction mux; scanning from the top way down lets way 0 win a double match.
    always_comb begin
        pred_hit     = 1'b0;
        sel_target_s = '0;
        sel_kind_s   = KIND_BR_NT;
        sel_ctr_s    = 2'd0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            pred_hit     = pred_hit | rd_hit_s[w];
            sel_target_s = rd_hit_s[w] ? rd_target_s[w] : sel_target_s;
            sel_kind_s   = rd_hit_s[w] ? rd_kind_s[w]   : sel_kind_s;
            sel_ctr_s    = rd_hit_s[w] ? rd_ctr_s[w]    : sel_ctr_s;
        end
        pred_taken = pred_hit && (kind_is_uncond(sel_kind_s) || sel_ctr_s[1]);
        pred_pc    = pred_taken ? sel_target_s : pc + WORD_SIZE'(1);
    end

    // Update path: hit way or victim (lowest invalid, else LRU) and the counter to write.
    always_comb begin
        up_any_hit_s    = 1'b0;
        up_way_s        = 1'b0;
        victim_s        = lru_s;
        up_cur_target_s = '0;
        up_cur_kind_s   = KIND_BR_NT;
        up_cur_ctr_s    = 2'd0;
        we_s            = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            up_any_hit_s    = up_any_hit_s | up_hit_s[w];
            up_way_s        = up_hit_s[w] ? 1'(w)          : up_way_s;
            up_cur_target_s = up_hit_s[w] ? up_target_s[w] : up_cur_target_s;
            up_cur_kind_s   = up_hit_s[w] ? up_kind_s[w]   : up_cur_kind_s;
            up_cur_ctr_s    = up_hit_s[w] ? up_ctr_s[w]    : up_cur_ctr_s;
            victim_s        = up_vld_s[w] ? victim_s       : 1'(w);
        end
        wr_way_s   = up_any_hit_s ? up_way_s : victim_s;
        wr_ctr_s   = up_any_hit_s ? ctr_train(up_cur_ctr_s, upd_kind_s) : ctr_init(upd_kind_s);
        do_write_s = upd_valid && !flush_all && (up_any_hit_s || (upd_kind_s != KIND_BR_NT));
        for (int w = 0; w < WAYS; w++) begin
            we_s[w] = do_write_s && (wr_way_s == 1'(w));
        end
    end

    if (WAYS == 2) begin : g_lru
        logic [SETS-1:0] lru_q, lru_d;

        // Each set's LRU bit names the way that was not written last.
        always_comb begin
            lru_d = lru_q;
            if (flush_all) begin
                lru_d = '0;
            end else if (do_write_s) begin
                lru_d[up_idx_s] = ~wr_way_s;
            end else begin
                lru_d = lru_q;
            end
        end

        // LRU state register.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                lru_q <= '0;
            end else begin
                lru_q <= lru_d;
            end
        end

        assign lru_s = lru_q[up_idx_s];
    end else begin : g_no_lru
        assign lru_s = 1'b0;
    end

`ifdef BTB_ASSOC_STATS_EN
    logic [15:0] lookups_q, lookups_d, hits_q, hits_d, misp_q, misp_d;
    logic        mispred_s, upd_taken_s, cur_dir_s;

    // A training event mispredicts when direction or target disagrees with the stored entry.
    always_comb begin
        upd_taken_s = kind_is_taken(upd_kind_s);
        cur_dir_s   = kind_is_uncond(up_cur_kind_s) || up_cur_ctr_s[1];
        mispred_s   = up_any_hit_s ?
                      ((cur_dir_s != upd_taken_s) || (upd_taken_s && (up_cur_target_s != upd_target))) :
                      upd_taken_s;
        lookups_d   = sat_inc16(lookups_q, 1'b1);
        hits_d      = sat_inc16(hits_q, pred_hit);
        misp_d      = sat_inc16(misp_q, upd_valid && mispred_s);
    end

    // Statistics registers; only reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lookups_q <= 16'd0;
            hits_q    <= 16'd0;
            misp_q    <= 16'd0;
        end else begin
            lookups_q <= lookups_d;
            hits_q    <= hits_d;
            misp_q    <= misp_d;
        end
    end

    assign stat_lookups = lookups_q;
    assign stat_hits    = hits_q;
    assign stat_mispred = misp_q;
`else
    logic unused_stats_s;
    assign unused_stats_s = ^{up_cur_target_s, 2'(up_cur_kind_s)};
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Randomised self-checking bench for btb_assoc: a 2-way and a 1-way instance
// share stimulus and are compared against a recency-ordered list model.
module tb_btb_assoc;
    localparam logic [1:0] K_JMP = 2'd0, K_BRT = 2'd1, K_BRNT = 2'd2, K_JR = 2'd3;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] tgt;
        logic [1:0]  kind;
        int          ctr;
    } ent_t;

    logic        clk = 1'b0, reset = 1'b1, upd_valid = 1'b0, flush_all = 1'b0;
    logic [15:0] pc = 16'h0040, upd_pc = 16'h0000, upd_target = 16'h0000;
    logic [1:0]  upd_kind = 2'd0;
    logic [15:0] p2_pc, p1_pc;
    logic        p2_hit, p2_taken, p1_hit, p1_taken;
`ifdef BTB_ASSOC_STATS_EN
    logic [15:0] s2_look, s2_hit, s2_misp, s1_look, s1_hit, s1_misp;
    logic [15:0] m_look = 16'd0, m_hit = 16'd0, m_misp = 16'd0;
`endif

    int   n_checks = 0, n_errors = 0;
    ent_t mq [2][$];   // [0]: 2-way model, [1]: 1-way model; front = most recently written
    logic [17:0] e2_s, e1_s;

    always #5 clk = ~clk;

    btb_assoc #(.WORD_SIZE(16), .IDX_BITS(6), .WAYS(2)) dut2 (
        .clk(clk), .reset(reset), .pc(pc), .pred_pc(p2_pc), .pred_hit(p2_hit),
        .pred_taken(p2_taken), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_kind(upd_kind), .upd_target(upd_target), .flush_all(flush_all)
`ifdef BTB_ASSOC_STATS_EN
        , .stat_lookups(s2_look), .stat_hits(s2_hit), .stat_mispred(s2_misp)
`endif
    );

    btb_assoc #(.WORD_SIZE(16), .IDX_BITS(6), .WAYS(1)) dut1 (
        .clk(clk), .reset(reset), .pc(pc), .pred_pc(p1_pc), .pred_hit(p1_hit),
        .pred_taken(p1_taken), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_kind(upd_kind), .upd_target(upd_target), .flush_all(flush_all)
`ifdef BTB_ASSOC_STATS_EN
        , .stat_lookups(s1_look), .stat_hits(s1_hit), .stat_mispred(s1_misp)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mdl_find(input int d, input logic [15:0] p);
        for (int i = 0; i < mq[d].size(); i++)
            if (mq[d][i].pc == p) return i;
        return -1;
    endfunction

    // {hit, taken, next pc}
    function automatic logic [17:0] mdl_predict(input int d, input logic [15:0] p);
        int i;
        logic tk;
        i = mdl_find(d, p);
        if (i < 0) return {1'b0, 1'b0, p + 16'd1};
        tk = (mq[d][i].kind == K_JMP) || (mq[d][i].kind == K_JR) || (mq[d][i].ctr >= 2);
        return {1'b1, tk, tk ? mq[d][i].tgt : p + 16'd1};
    endfunction

    task automatic mdl_update(input int d, input logic [15:0] p, input logic [1:0] k, input logic [15:0] t);
        int   i, cnt, last, ways;
        ent_t e;
        ways = (d == 0) ? 2 : 1;
        i = mdl_find(d, p);
        if (i >= 0) begin
            e = mq[d][i];
            e.tgt  = t;
            e.kind = k;
            if (k == K_BRT)       e.ctr = (e.ctr < 3) ? e.ctr + 1 : 3;
            else if (k == K_BRNT) e.ctr = (e.ctr > 0) ? e.ctr - 1 : 0;
            else                  e.ctr = 3;
            mq[d].delete(i);
            mq[d].push_front(e);
        end else if (k != K_BRNT) begin
            cnt = 0;
            last = -1;
            for (int j = 0; j < mq[d].size(); j++)
                if (mq[d][j].pc[5:0] == p[5:0]) begin cnt++; last = j; end
            if (cnt >= ways) mq[d].delete(last);
            e.pc = p; e.tgt = t; e.kind = k; e.ctr = (k == K_BRT) ? 2 : 3;
            mq[d].push_front(e);
        end
    endtask

    task automatic mdl_clear();
        mq[0].delete();
        mq[1].delete();
`ifdef BTB_ASSOC_STATS_EN
        m_look = 16'd0; m_hit = 16'd0; m_misp = 16'd0;
`endif
    endtask

    always @(posedge reset) mdl_clear();

    // Model advances on the same edge as the DUT, using the pre-edge contents.
    always @(posedge clk) begin
        if (reset) begin
            mdl_clear();
        end else begin
`ifdef BTB_ASSOC_STATS_EN
            begin
                int   i;
                logic dir, tk, mp;
                if (m_look != 16'hFFFF) m_look++;
                if (mdl_predict(0, pc) >> 17 != 0 && m_hit != 16'hFFFF) m_hit++;
                tk = (upd_kind != K_BRNT);
                i = mdl_find(0, upd_pc);
                if (i >= 0) begin
                    dir = (mq[0][i].kind == K_JMP) || (mq[0][i].kind == K_JR) || (mq[0][i].ctr >= 2);
                    mp  = (dir != tk) || (tk && (mq[0][i].tgt != upd_target));
                end else begin
                    mp = tk;
                end
                if (upd_valid && mp && m_misp != 16'hFFFF) m_misp++;
            end
`endif
            if (flush_all) begin
                mq[0].delete();
                mq[1].delete();
            end else if (upd_valid) begin
                mdl_update(0, upd_pc, upd_kind, upd_target);
                mdl_update(1, upd_pc, upd_kind, upd_target);
            end
        end
    end

    // Continuous comparison of both instances against the model.
    always @(negedge clk) begin
        e2_s = mdl_predict(0, pc);
        e1_s = mdl_predict(1, pc);
        check_eq("w2_hit",   {31'd0, p2_hit},   {31'd0, e2_s[17]});
        check_eq("w2_taken", {31'd0, p2_taken}, {31'd0, e2_s[16]});
        check_eq("w2_pc",    {16'd0, p2_pc},    {16'd0, e2_s[15:0]});
        check_eq("w1_hit",   {31'd0, p1_hit},   {31'd0, e1_s[17]});
        check_eq("w1_taken", {31'd0, p1_taken}, {31'd0, e1_s[16]});
        check_eq("w1_pc",    {16'd0, p1_pc},    {16'd0, e1_s[15:0]});
`ifdef BTB_ASSOC_STATS_EN
        check_eq("stat_lookups", {16'd0, s2_look}, {16'd0, m_look});
        check_eq("stat_hits",    {16'd0, s2_hit},  {16'd0, m_hit});
        check_eq("stat_mispred", {16'd0, s2_misp}, {16'd0, m_misp});
`endif
    end

    task automatic drive(input logic [15:0] p, input logic uv, input logic [15:0] up,
                         input logic [1:0] k, input logic [15:0] t, input logic fl);
        @(posedge clk);
        #2;
        pc = p; upd_valid = uv; upd_pc = up; upd_kind = k; upd_target = t; flush_all = fl;
        @(negedge clk);
        #1;
    endtask

    task automatic look(input logic [15:0] p);
        drive(p, 1'b0, 16'h0000, K_JMP, 16'h0000, 1'b0);
    endtask

    task automatic train(input logic [15:0] p, input logic [1:0] k, input logic [15:0] t);
        drive(p, 1'b1, p, k, t, 1'b0);
    endtask

    task automatic expect_pred(input string tag, input int d, input logic h, input logic tk,
                               input logic [15:0] npc);
        if (d == 0) begin
            check_eq({tag, "_hit2"},   {31'd0, p2_hit},   {31'd0, h});
            check_eq({tag, "_taken2"}, {31'd0, p2_taken}, {31'd0, tk});
            check_eq({tag, "_pc2"},    {16'd0, p2_pc},    {16'd0, npc});
        end else begin
            check_eq({tag, "_hit1"},   {31'd0, p1_hit},   {31'd0, h});
            check_eq({tag, "_taken1"}, {31'd0, p1_taken}, {31'd0, tk});
            check_eq({tag, "_pc1"},    {16'd0, p1_pc},    {16'd0, npc});
        end
    endtask

    function automatic logic [15:0] rnd_pc();
        logic [5:0] i;
        logic [9:0] t;
        case ($urandom_range(3))
            0:       i = 6'd0;
            1:       i = 6'd5;
            2:       i = 6'd63;
            default: i = 6'($urandom);
        endcase
        case ($urandom_range(3))
            0:       t = 10'd0;
            1:       t = 10'd1;
            2:       t = 10'd2;
            default: t = 10'h3FF;
        endcase
        return {t, i};
    endfunction

    initial begin
        #1;
        expect_pred("in_reset", 0, 1'b0, 1'b0, 16'h0041);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;

        look(16'h0040);  expect_pred("rst_0040", 0, 1'b0, 1'b0, 16'h0041);
        look(16'hFFFF);  expect_pred("wrap", 0, 1'b0, 1'b0, 16'h0000);
        expect_pred("wrap", 1, 1'b0, 1'b0, 16'h0000);

        train(16'h0040, K_JMP, 16'h0100);  expect_pred("same_cyc", 0, 1'b0, 1'b0, 16'h0041);
        look(16'h0040);  expect_pred("jmp_hit", 0, 1'b1, 1'b1, 16'h0100);

        train(16'h0085, K_BRT, 16'h0200);
        train(16'h0085, K_BRNT, 16'h0200);
        look(16'h0085);  expect_pred("br_weak_nt", 0, 1'b1, 1'b0, 16'h0086);
        repeat (3) train(16'h0085, K_BRT, 16'h0200);
        look(16'h0085);  expect_pred("br_sat", 0, 1'b1, 1'b1, 16'h0200);

        train(16'h0123, K_BRNT, 16'h0300);
        look(16'h0123);  expect_pred("brnt_miss", 0, 1'b0, 1'b0, 16'h0124);

        train(16'h0045, K_JMP, 16'h0300);
        look(16'h0045);  expect_pred("set5_a", 0, 1'b1, 1'b1, 16'h0300);
        look(16'h0085);  expect_pred("set5_b", 0, 1'b1, 1'b1, 16'h0200);
        expect_pred("w1_evict", 1, 1'b0, 1'b0, 16'h0086);
        train(16'h0045, K_JMP, 16'h0301);
        train(16'h00C5, K_JR, 16'h0400);
        look(16'h0085);  expect_pred("lru_evict", 0, 1'b0, 1'b0, 16'h0086);
        look(16'h0045);  expect_pred("lru_keep", 0, 1'b1, 1'b1, 16'h0301);
        expect_pred("w1_evict2", 1, 1'b0, 1'b0, 16'h0046);
        look(16'h00C5);  expect_pred("new_c5", 0, 1'b1, 1'b1, 16'h0400);
        expect_pred("new_c5", 1, 1'b1, 1'b1, 16'h0400);

        drive(16'h0777, 1'b1, 16'h0777, K_JMP, 16'h0500, 1'b1);
        look(16'h0777);  expect_pred("flush_upd", 0, 1'b0, 1'b0, 16'h0778);
        look(16'h0045);  expect_pred("flush_old", 0, 1'b0, 1'b0, 16'h0046);

        train(16'h0040, K_JMP, 16'h0100);
        train(16'h0085, K_BRT, 16'h0200);
        look(16'h0040);  expect_pred("retrain", 0, 1'b1, 1'b1, 16'h0100);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        expect_pred("async_rst", 0, 1'b0, 1'b0, 16'h0041);
        expect_pred("async_rst", 1, 1'b0, 1'b0, 16'h0041);
        @(posedge clk);
        #2 reset = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            reset      = ($urandom_range(299) == 0);
            flush_all  = ($urandom_range(39) == 0);
            upd_valid  = ($urandom_range(1) == 1);
            upd_kind   = 2'($urandom_range(3));
            upd_pc     = rnd_pc();
            pc         = ($urandom_range(2) == 0) ? upd_pc : rnd_pc();
            upd_target = ($urandom_range(1) == 0) ? 16'h0200 : 16'($urandom);
        end
        @(posedge clk);
        #2;
        reset = 1'b0; upd_valid = 1'b0; flush_all = 1'b0;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
